// File: rtl/sd_decimator.sv
// sd_decimator: maps a 3-bit sigma-delta bitstream to a +/-1 sum and decimates it with a 2nd-order CIC.
// Build macro SD_DECIM_HOLD_EN: on overrun keep the held sample (oldest-wins) instead of overwriting it.
module sd_decimator #(
    parameter int BITWIDTH = 32,
    parameter int DECIM = 64,
    parameter int CNTW = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [2:0]          sd_in,
    input  logic                in_valid,
    input  logic                clr_overrun,
    output logic [BITWIDTH-1:0] sample_out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                overrun,
    output logic [CNTW-1:0]     phase
);
`ifdef SD_DECIM_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif
    typedef enum logic {EMPTY, FULL} state_t;
    state_t state, state_nx;
    logic [1:0] ones;
    logic [BITWIDTH-1:0] x, int1, int2, int2_nx, s_d, c1, c1_d, c2;
    logic ev, load, set_ov;
    // Input mapping, comb stage arithmetic and output-stage decisions
    always_comb begin
        ones = {1'b0, sd_in[0]} + {1'b0, sd_in[1]} + {1'b0, sd_in[2]};
        x = BITWIDTH'(3) - BITWIDTH'({ones, 1'b0});
        int2_nx = int2 + int1;
        c1 = int2_nx - s_d;
        c2 = c1 - c1_d;
        ev = in_valid && (phase == CNTW'(DECIM - 1));
        set_ov = ev && state == FULL && !out_ready;
        load = ev && (state == EMPTY || out_ready || !HOLD);
        state_nx = ev ? FULL : (state == FULL && out_ready) ? EMPTY : state;
    end
    // Integrators, phase counter and comb delays advance on accepted inputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            int1 <= '0;
            int2 <= '0;
            s_d <= '0;
            c1_d <= '0;
            phase <= '0;
        end else if (in_valid) begin
            int1 <= int1 + x;
            int2 <= int2_nx;
            phase <= ev ? '0 : phase + CNTW'(1);
            if (ev) begin
                s_d <= int2_nx;
                c1_d <= c1;
            end
        end
    end
    // Output holding register, state and sticky overrun flag (set beats clear)
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= EMPTY;
            sample_out <= '0;
            overrun <= 1'b0;
        end else begin
            state <= state_nx;
            if (load) sample_out <= c2;
            overrun <= set_ov ? 1'b1 : clr_overrun ? 1'b0 : overrun;
        end
    end
    assign out_valid = (state == FULL);
endmodule

// File: tb/tb_sd_decimator.sv
// tb_sd_decimator: randomized and directed checks of sd_decimator against a closed-form CIC reference model.
module tb_sd_decimator;
    localparam int D = 64;
`ifdef SD_DECIM_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif
    logic clk = 0, reset = 0, in_valid = 0, clr_overrun = 0, out_ready = 0;
    logic [2:0] sd_in = 0;
    logic [31:0] sample_out;
    logic out_valid, overrun;
    logic [15:0] phase;
    int checks = 0, errors = 0;
    int xs[$];
    longint s_prev, c1_prev;
    logic [31:0] m_sample;
    logic m_valid, m_ov;

    sd_decimator #(.BITWIDTH(32), .DECIM(D), .CNTW(16)) dut (
        .clk(clk), .reset(reset), .sd_in(sd_in), .in_valid(in_valid),
        .clr_overrun(clr_overrun), .sample_out(sample_out), .out_valid(out_valid),
        .out_ready(out_ready), .overrun(overrun), .phase(phase)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // int2 after n inputs is sum_j x_j*(n-1-j); the CIC output is its second difference across windows.
    task automatic model(input logic [2:0] s, input logic v, input logic r, input logic c, input logic rs);
        bit ev, hs, set;
        longint sv, c1, c2;
        int n;
        if (!rs) begin
            xs.delete();
            s_prev = 0; c1_prev = 0;
            m_sample = 0; m_valid = 0; m_ov = 0;
            return;
        end
        ev = v && (xs.size() % D == D - 1);
        hs = m_valid && r;
        set = 0;
        if (v) xs.push_back(3 - 2 * $countones(s));
        if (ev) begin
            n = xs.size();
            sv = 0;
            foreach (xs[j]) sv += longint'(xs[j]) * longint'(n - 1 - j);
            c1 = sv - s_prev;
            c2 = c1 - c1_prev;
            s_prev = sv; c1_prev = c1;
            if (!m_valid || hs) begin
                m_sample = c2[31:0]; m_valid = 1;
            end else begin
                set = 1;
                if (!HOLD) m_sample = c2[31:0];
            end
        end else if (hs) m_valid = 0;
        m_ov = set ? 1'b1 : c ? 1'b0 : m_ov;
    endtask

    task automatic tick(input logic [2:0] s, input logic v, input logic r, input logic c, input logic rs);
        sd_in = s; in_valid = v; out_ready = r; clr_overrun = c; reset = rs;
        @(posedge clk);
        model(s, v, r, c, rs);
        #1;
        check("phase", 32'(phase), 32'(xs.size() % D));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("sample_out", sample_out, m_sample);
        check("overrun", 32'(overrun), 32'(m_ov));
    endtask

    initial begin
        #1;
        for (int i = 0; i < 3; i++) tick(3'($urandom), 1, 1, 0, 0);
        check("reset_valid", 32'(out_valid), 0);
        check("reset_sample", sample_out, 0);
        for (int i = 0; i < 4 * D; i++) tick(3'b000, 1, 1, 0, 1);
        check("steady_pos", sample_out, 32'd12288);
        tick(3'b000, 1, 1, 0, 0);
        for (int i = 0; i < 4 * D; i++) tick(3'b111, 1, 1, 0, 1);
        check("steady_neg", sample_out, 32'hFFFFD000);
        tick(3'b000, 1, 1, 0, 0);
        for (int i = 0; i < 4 * D; i++) tick((i % 2) ? 3'b110 : 3'b001, 1, 1, 0, 1);
        check("alt_valid", 32'(out_valid), 1);
        check("alt_zero", sample_out, 0);
        tick(3'b000, 1, 1, 0, 0);
        for (int i = 0; i < 8 * D; i++) tick(3'b000, logic'(i % 2), 1, 0, 1);
        check("gap_valid", 32'(out_valid), 1);
        check("gap_sample", sample_out, 32'd12288);
        tick(3'b000, 1, 1, 0, 0);
        for (int i = 0; i < 2 * D; i++) tick(3'b000, 1, 0, 0, 1);
        check("ovr_set", 32'(overrun), 1);
        check("ovr_data", sample_out, HOLD ? 32'd6048 : 32'd12288);
        tick(3'b000, 0, 0, 1, 1);
        check("ovr_clr", 32'(overrun), 0);
        for (int i = 0; i < D - 1; i++) tick(3'b001, 1, 0, 0, 1);
        tick(3'b001, 1, 1, 0, 1);
        check("hs_ev_ovr", 32'(overrun), 0);
        check("hs_ev_valid", 32'(out_valid), 1);
        tick(3'b000, 0, 1, 0, 0);
        for (int i = 0; i < 30; i++) tick(3'b010, 1, 1, 0, 1);
        check("mid_phase", 32'(phase), 30);
        tick(3'b010, 1, 1, 0, 0);
        check("mid_rst_phase", 32'(phase), 0);
        for (int i = 0; i < D - 1; i++) tick(3'b010, 1, 1, 0, 1);
        check("mid_not_yet", 32'(out_valid), 0);
        tick(3'b010, 1, 1, 0, 1);
        check("mid_emit", 32'(out_valid), 1);
        for (int i = 0; i < 3000; i++)
            tick(3'($urandom), $urandom_range(0, 9) < 8, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 799) != 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
